pe_dbuf: RTL
============

Name: pe_dbuf

Overview:
- Parametrised systolic-array processing element; next generation of the array's current 8-bit PE.
- Adds: configurable operand and partial-sum widths, a signed/unsigned mode, and a double-buffered weight (shadow plus active) so the next tile's weights stream in while the current tile computes.
- Adds valid-qualified activation and partial-sum pipelines, and optional saturation with a sticky overflow flag.
- Instantiated SIZE x SIZE in the array: weights flow down, activations flow right, partial sums flow down.

Parameters:
- DATA_WIDTH, 8: activation and weight width.
- SIZE, 8: array dimension; sets partial-sum growth.
- PSUM_WIDTH, 2*DATA_WIDTH+$clog2(SIZE) (19 at defaults): partial-sum width.
- SATURATE, 1: 1 = clamp on overflow; 0 = two's-complement wrap.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- signed_mode, in, 1: 1 = signed operands and psum; 0 = unsigned.
- weight_in, in, DATA_WIDTH: weight from the PE above.
- weight_in_valid, in, 1: load weight_in into the shadow register.
- weight_swap, in, 1: copy shadow to active.
- weight_pass, out, DATA_WIDTH: shadow register; feeds the PE below.
- weight_pass_valid, out, 1: registered weight_in_valid.
- weight_swap_pass, out, 1: registered weight_swap.
- act_in, in, DATA_WIDTH: activation from the left.
- act_in_valid, in, 1: activation valid.
- act_pass, out, DATA_WIDTH: registered activation to the right.
- act_pass_valid, out, 1: registered act_in_valid.
- psum_in, in, PSUM_WIDTH: partial sum from above.
- psum_out, out, PSUM_WIDTH: registered partial sum downward.
- psum_out_valid, out, 1: psum_out valid.
- ovf, out, 1: sticky overflow flag.
- clr_ovf, in, 1: synchronous clear of ovf.

Behaviour:

Reset
- rst_n low clears asynchronously: shadow, active, weight_pass_valid, weight_swap_pass, act_pass, act_pass_valid, psum_out, psum_out_valid, ovf.
- Reset mid-load or mid-compute discards all state; no partial results survive.

Weight path
- Every edge: weight_pass_valid <= weight_in_valid; weight_swap_pass <= weight_swap. Both are 1-cycle daisy-chain delays.
- weight_in_valid=1: shadow <= weight_in. Otherwise shadow holds.
- weight_swap=1: active <= shadow (the value before this edge).
- Load and swap in the same cycle: active gets the old shadow; shadow gets weight_in.
- The active weight changes only on swap. Weight loading never stalls or disturbs compute.

Compute path (act_in_valid=1)
- Product: act_in*active. Computed as signed DATA_WIDTH x DATA_WIDTH when signed_mode=1, unsigned otherwise.
- The 2*DATA_WIDTH product is sign- or zero-extended to PSUM_WIDTH+1 and added to psum_in, extended the same way.
- Overflow is detected on the PSUM_WIDTH+1 result:
  - Signed: the result falls outside [-2^(PSUM_WIDTH-1), 2^(PSUM_WIDTH-1)-1].
  - Unsigned: the result exceeds 2^PSUM_WIDTH-1.
- SATURATE=1: clamp to the violated bound. SATURATE=0: truncate (wrap).
- psum_out <= result; psum_out_valid <= 1; act_pass <= act_in; act_pass_valid <= 1. Latency 1 cycle.
- Zero operand (act_in==0 or active==0): product treated as exactly 0, so psum_out = psum_in.

Compute path (act_in_valid=0)
- psum_out and act_pass hold their values.
- psum_out_valid and act_pass_valid go to 0.
- ovf unaffected.

Overflow flag
- ovf set on any overflowing valid MAC, in either SATURATE setting.
- clr_ovf clears it next cycle.
- Set and clear in the same cycle: set wins.

Mode
- signed_mode is sampled each cycle and applies to that cycle's MAC only. Changing it mid-stream is legal and takes effect immediately.

Test Plan:
- Defaults, signed. Load 0xFD (-3), then pulse weight_swap. Apply act_in=0x05, psum_in=10, valid. Next cycle: psum_out=-5, psum_out_valid=1, act_pass=0x05.
- Double buffer. Active=2. In the same cycle, load 7 and apply act=3, psum 0: psum_out=6. Then swap while loading 9: active=7, shadow=9. Next act=3 gives psum_out=21.
- Unsigned mode. Active=0xFF, act=0xFF, psum_in=0: psum_out=65025 (not 1). Same operands with signed_mode=1: psum_out=1.
- Saturation. SATURATE=1, signed, psum_in=262143 (max), act=1, weight=1: psum_out=262143 and ovf=1. Assert clr_ovf together with a second overflowing MAC: ovf stays 1. Clear with no MAC: ovf=0. With SATURATE=0 the same stimulus gives psum_out=-262144.
- Bubbles. Toggle act_in_valid 1,0,1: psum_out_valid follows one cycle later; psum_out holds across the bubble. weight_pass_valid and weight_swap_pass are one-cycle delays of their inputs.
- Reset. Drop rst_n asynchronously mid-stream, between clock edges: all outputs read 0 immediately. After release, active=0, so any act gives psum_out=psum_in.

Source files
------------

// File: rtl/pe_dbuf.sv
// Systolic PE: double-buffered weight, valid-qualified MAC,
// signed/unsigned mode, optional saturation with sticky overflow.
module pe_dbuf #(
   parameter int DATA_WIDTH = 8,
   parameter int SIZE       = 8,
   parameter int PSUM_WIDTH = 2*DATA_WIDTH+$clog2(SIZE),
   parameter bit SATURATE   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  signed_mode,
   input  logic [DATA_WIDTH-1:0] weight_in,
   input  logic                  weight_in_valid,
   input  logic                  weight_swap,
   output logic [DATA_WIDTH-1:0] weight_pass,
   output logic                  weight_pass_valid,
   output logic                  weight_swap_pass,
   input  logic [DATA_WIDTH-1:0] act_in,
   input  logic                  act_in_valid,
   output logic [DATA_WIDTH-1:0] act_pass,
   output logic                  act_pass_valid,
   input  logic [PSUM_WIDTH-1:0] psum_in,
   output logic [PSUM_WIDTH-1:0] psum_out,
   output logic                  psum_out_valid,
   output logic                  ovf,
   input  logic                  clr_ovf
);

   localparam int DW = DATA_WIDTH;
   localparam int PW = PSUM_WIDTH;
   localparam int EW = PW + 1;
   localparam int XW = EW - 2*DW;

   logic [DW-1:0]   shadow;
   logic [DW-1:0]   active;
   logic [2*DW-1:0] a_x;
   logic [2*DW-1:0] w_x;
   logic [2*DW-1:0] prod;
   logic [EW-1:0]   prod_x;
   logic [EW-1:0]   psum_x;
   logic [EW-1:0]   sum;
   logic [PW-1:0]   res;
   logic            of;

   // Low 2*DW bits of the extended product are exact in both modes
   always_comb begin
      a_x    = {{DW{signed_mode & act_in[DW-1]}}, act_in};
      w_x    = {{DW{signed_mode & active[DW-1]}}, active};
      prod   = a_x * w_x;
      prod_x = {{XW{signed_mode & prod[2*DW-1]}}, prod};
      psum_x = {signed_mode & psum_in[PW-1], psum_in};
      sum    = prod_x + psum_x;
      res    = sum[PW-1:0];
      of     = signed_mode ? (sum[EW-1] ^ sum[PW-1]) : sum[EW-1];
      if (SATURATE && of) begin
         if (!signed_mode)
            res = '1;
         else if (sum[EW-1])
            res = {1'b1, {(PW-1){1'b0}}};
         else
            res = {1'b0, {(PW-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow            <= '0;
         active            <= '0;
         weight_pass_valid <= 1'b0;
         weight_swap_pass  <= 1'b0;
      end else begin
         weight_pass_valid <= weight_in_valid;
         weight_swap_pass  <= weight_swap;
         if (weight_in_valid)
            shadow <= weight_in;
         if (weight_swap)
            active <= shadow;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_pass       <= '0;
         act_pass_valid <= 1'b0;
         psum_out       <= '0;
         psum_out_valid <= 1'b0;
      end else begin
         act_pass_valid <= act_in_valid;
         psum_out_valid <= act_in_valid;
         if (act_in_valid) begin
            act_pass <= act_in;
            psum_out <= res;
         end
      end
   end

   // Set has priority over clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf <= 1'b0;
      else if (act_in_valid && of)
         ovf <= 1'b1;
      else if (clr_ovf)
         ovf <= 1'b0;
   end

   assign weight_pass = shadow;

endmodule
